// File: rtl/sonic_sensor_array_if.sv
`timescale 1ns/1ps
// sonic_sensor_array_if: control and readback port of the ultrasonic sensor array.
// The master (robot control logic) requests sweeps and reads results;
// the slave (sonic_sensor_array) reports status and serves results.
interface sonic_sensor_array_if #(
   parameter int CH = 4,
   parameter int CW = 32
);
   localparam int SW = (CH > 1) ? $clog2(CH) : 1;

   logic          start;
   logic          cont;
   logic [CH-1:0] ch_mask;
   logic          busy;
   logic          done;
   logic [CH-1:0] valid;
   logic [SW-1:0] rd_sel;
   logic [CW-1:0] rd_data;
   logic          rd_timeout;

   modport master (
      output start, cont, ch_mask, rd_sel,
      input  busy, done, valid, rd_data, rd_timeout
   );

   modport slave (
      input  start, cont, ch_mask, rd_sel,
      output busy, done, valid, rd_data, rd_timeout
   );
endinterface

// File: rtl/sonic_sensor_array.sv
`timescale 1ns/1ps
// sonic_sensor_array: controller for single-wire ultrasonic rangers.
// Enabled channels are fired one at a time in ascending index order so that
// neighbouring sensors cannot crosstalk. Each channel's echo high-time is
// measured in clk cycles and stored with a timeout flag; results are read
// back through a combinational register-style port.
module sonic_sensor_array #(
   parameter int CH           = 4,
   parameter int CW           = 32,
   parameter int TRIG_CYC     = 500,
   parameter int RISE_MAX_CYC = 75000,
   parameter int ECHO_MAX_CYC = 1850000,
   parameter int GUARD_CYC    = 20000
) (
   input  logic                 clk,
   input  logic                 rst,
   sonic_sensor_array_if.slave  bus,
   inout  wire  [CH-1:0]        sig
);
   localparam int SW = (CH > 1) ? $clog2(CH) : 1;

   localparam logic [CW-1:0] CNT_ZERO   = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] TRIG_LAST  = CW'(TRIG_CYC - 1);
   localparam logic [CW-1:0] RISE_LAST  = CW'(RISE_MAX_CYC - 1);
   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] ECHO_MAX_C = CW'(ECHO_MAX_CYC);
   localparam logic [CH-1:0] CH_ZERO    = {CH{1'b0}};
   localparam logic [CH-1:0] CH_ONE     = {{(CH-1){1'b0}}, 1'b1};

   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_SELECT    = 3'd1,
      S_TRIG      = 3'd2,
      S_WAIT_RISE = 3'd3,
      S_MEASURE   = 3'd4,
      S_GUARD     = 3'd5,
      S_SWEEP_END = 3'd6
   } state_t;

   state_t        state_r;
   logic [CH-1:0] mask_r;
   logic [CH-1:0] drive_r;
   logic [CH-1:0] sync1_r;
   logic [CH-1:0] sync2_r;
   logic [CH-1:0] valid_r;
   logic [CH-1:0] to_r;
   logic [SW-1:0] cur_r;
   logic [CW-1:0] cnt_r;
   logic          busy_r;
   logic          done_r;
   logic [CW-1:0] res_r [CH];

   logic [CH-1:0] low_bit_s;
   logic [SW-1:0] low_idx_s;
   logic          echo_s;
   logic [CW-1:0] cnt_inc_s;

   // Convert a one-hot channel vector into its index (all-zero input gives 0).
   function automatic logic [SW-1:0] onehot_to_idx(input logic [CH-1:0] oh);
      logic [SW-1:0] idx;
      idx = {SW{1'b0}};
      for (int i = 0; i < CH; i++) begin
         idx = idx | (oh[i] ? SW'(i) : {SW{1'b0}});
      end
      return idx;
   endfunction

   // Pins are only ever pulled high by us during the trigger; otherwise released.
   for (genvar g = 0; g < CH; g++) begin : g_pin
      assign sig[g] = drive_r[g] ? 1'b1 : 1'bz;
   end

   // Lowest pending channel, the echo of the current channel and the next count value.
   always_comb begin
      low_bit_s = mask_r & (~mask_r + CH_ONE);
      low_idx_s = onehot_to_idx(low_bit_s);
      echo_s    = sync2_r[cur_r];
      cnt_inc_s = cnt_r + CNT_ONE;
   end

   // Two-flop pin synchroniser; a pin we are driving reads as 0 so our own trigger is never taken for an echo.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1_r <= CH_ZERO;
         sync2_r <= CH_ZERO;
      end else begin
         sync1_r <= sig & ~drive_r;
         sync2_r <= sync1_r;
      end
   end

   // Sweep sequencer: select, trigger, wait for echo, measure, guard, repeat.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
         mask_r  <= CH_ZERO;
         drive_r <= CH_ZERO;
         valid_r <= CH_ZERO;
         to_r    <= CH_ZERO;
         cur_r   <= {SW{1'b0}};
         cnt_r   <= CNT_ZERO;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         for (int i = 0; i < CH; i++) begin
            res_r[i] <= CNT_ZERO;
         end
      end else begin
         done_r <= 1'b0;
         case (state_r)
            S_IDLE: begin
               if (bus.start) begin
                  mask_r  <= bus.ch_mask;
                  busy_r  <= 1'b1;
                  state_r <= S_SELECT;
               end
            end
            S_SELECT: begin
               if (mask_r != CH_ZERO) begin
                  cur_r   <= low_idx_s;
                  mask_r  <= mask_r & ~low_bit_s;
                  drive_r <= low_bit_s;
                  cnt_r   <= CNT_ZERO;
                  state_r <= S_TRIG;
               end else begin
                  done_r  <= 1'b1;
                  state_r <= S_SWEEP_END;
               end
            end
            S_TRIG: begin
               if (cnt_r == TRIG_LAST) begin
                  drive_r <= CH_ZERO;
                  cnt_r   <= CNT_ZERO;
                  state_r <= S_WAIT_RISE;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            S_WAIT_RISE: begin
               if (echo_s) begin
                  // The cycle that saw the rising edge is already part of the high time.
                  cnt_r   <= CNT_ONE;
                  state_r <= S_MEASURE;
               end else if (cnt_r == RISE_LAST) begin
                  res_r[cur_r]   <= CNT_ZERO;
                  to_r[cur_r]    <= 1'b1;
                  valid_r[cur_r] <= 1'b1;
                  cnt_r          <= CNT_ZERO;
                  state_r        <= S_GUARD;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            S_MEASURE: begin
               if (!echo_s) begin
                  res_r[cur_r]   <= cnt_r;
                  to_r[cur_r]    <= 1'b0;
                  valid_r[cur_r] <= 1'b1;
                  cnt_r          <= CNT_ZERO;
                  state_r        <= S_GUARD;
               end else if (cnt_inc_s == ECHO_MAX_C) begin
                  res_r[cur_r]   <= ECHO_MAX_C;
                  to_r[cur_r]    <= 1'b1;
                  valid_r[cur_r] <= 1'b1;
                  cnt_r          <= CNT_ZERO;
                  state_r        <= S_GUARD;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            S_GUARD: begin
               if (cnt_r == GUARD_LAST) begin
                  cnt_r   <= CNT_ZERO;
                  state_r <= S_SELECT;
               end else begin
                  cnt_r <= cnt_inc_s;
               end
            end
            S_SWEEP_END: begin
               if (bus.cont) begin
                  mask_r  <= bus.ch_mask;
                  state_r <= S_SELECT;
               end else begin
                  busy_r  <= 1'b0;
                  state_r <= S_IDLE;
               end
            end
            default: begin
               drive_r <= CH_ZERO;
               busy_r  <= 1'b0;
               cnt_r   <= CNT_ZERO;
               state_r <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.busy       = busy_r;
   assign bus.done       = done_r;
   assign bus.valid      = valid_r;
   assign bus.rd_data    = (int'(bus.rd_sel) < CH) ? res_r[bus.rd_sel] : CNT_ZERO;
   assign bus.rd_timeout = (int'(bus.rd_sel) < CH) ? to_r[bus.rd_sel] : 1'b0;
endmodule

// File: tb/tb_sonic_sensor_array.sv
`timescale 1ns/1ps
// tb_sonic_sensor_array: randomized scoreboard bench with a behavioural sensor model.
module tb_sonic_sensor_array;
   localparam int CH = 4;
   localparam int CW = 32;
   localparam int SW = 2;
   localparam int TRIG_CYC = 5;
   localparam int RISE_MAX_CYC = 20;
   localparam int ECHO_MAX_CYC = 100;
   localparam int GUARD_CYC = 10;

   typedef struct packed {
      logic [CH-1:0][CW-1:0] res;
      logic [CH-1:0]         to;
      logic [CH-1:0]         valid;
   } snap_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   wire  [CH-1:0] sig_w;
   logic [CH-1:0] sens_en = '0;

   sonic_sensor_array_if #(.CH(CH), .CW(CW)) bus ();

   sonic_sensor_array #(
      .CH(CH), .CW(CW), .TRIG_CYC(TRIG_CYC), .RISE_MAX_CYC(RISE_MAX_CYC),
      .ECHO_MAX_CYC(ECHO_MAX_CYC), .GUARD_CYC(GUARD_CYC)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus),
      .sig(sig_w)
   );

   for (genvar g = 0; g < CH; g++) begin : g_pin
      assign sig_w[g] = sens_en[g] ? 1'b1 : 1'bz;
      pulldown (sig_w[g]);
   end

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   bit chk_req = 1'b0;
   int last_trig_end = -1;

   // sensor behaviour: delay after trigger end, echo length (0 = never rises, -1 = stuck high)
   int sens_delay [CH];
   int sens_len [CH];
   int sens_cd [CH];
   int sens_hl [CH];
   int trig_len [CH];

   // reference model of the result registers
   logic [CW-1:0] m_res [CH];
   logic [CH-1:0] m_to;
   logic [CH-1:0] m_valid;

   snap_t exp_q [$];
   int    exp_trig_q [$];

   initial forever #5 clk = ~clk;
   initial forever begin @(posedge clk); cyc++; end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push_snapshot();
      snap_t s;
      for (int c = 0; c < CH; c++) s.res[c] = m_res[c];
      s.to = m_to;
      s.valid = m_valid;
      exp_q.push_back(s);
   endtask

   // Expected outcome of one sweep from the sensor behaviour currently configured.
   task automatic plan_sweep(input logic [CH-1:0] mask);
      for (int c = 0; c < CH; c++) begin
         if (mask[c]) begin
            exp_trig_q.push_back(c);
            if (sens_len[c] == 0) begin
               m_res[c] = '0; m_to[c] = 1'b1;
            end else if (sens_len[c] < 0 || sens_len[c] >= ECHO_MAX_CYC) begin
               m_res[c] = CW'(ECHO_MAX_CYC); m_to[c] = 1'b1;
            end else begin
               m_res[c] = CW'(sens_len[c]); m_to[c] = 1'b0;
            end
            m_valid[c] = 1'b1;
         end
      end
      push_snapshot();
   endtask

   task automatic check_trigger(input int c, input int len);
      int e;
      if (exp_trig_q.size() == 0) begin
         total++; bad++;
         $display("FAIL trig_unexpected: channel %0d fired, none expected", c);
      end else begin
         e = exp_trig_q.pop_front();
         chk("trig_channel", c, e);
      end
      chk("trig_length", len, TRIG_CYC);
      if (last_trig_end >= 0) chk("trig_guard_gap", ((cyc - len) - last_trig_end) >= GUARD_CYC, 1);
      last_trig_end = cyc;
   endtask

   // Sensor model and trigger observer, evaluated on the falling edge.
   initial begin
      forever begin
         @(negedge clk);
         for (int c = 0; c < CH; c++) begin
            if (rst) begin
               sens_en[c] = 1'b0; sens_cd[c] = 0; sens_hl[c] = 0; trig_len[c] = 0;
            end else if (!sens_en[c] && sig_w[c] === 1'b1) begin
               trig_len[c]++;
            end else if (trig_len[c] != 0) begin
               check_trigger(c, trig_len[c]);
               trig_len[c] = 0;
               if (sens_len[c] != 0) sens_cd[c] = sens_delay[c];
            end else if (sens_cd[c] > 0) begin
               sens_cd[c]--;
               if (sens_cd[c] == 0) begin sens_en[c] = 1'b1; sens_hl[c] = sens_len[c]; end
            end else if (sens_en[c] && sens_hl[c] > 0) begin
               sens_hl[c]--;
               if (sens_hl[c] == 0) sens_en[c] = 1'b0;
            end
         end
      end
   end

   // Scoreboard monitor: on each done pulse (or explicit check request) read back every channel.
   initial begin
      snap_t s;
      bus.rd_sel = '0;
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1 || chk_req) begin
            if (bus.done === 1'b1) done_cnt++;
            if (exp_q.size() == 0) begin
               total++; bad++;
               $display("FAIL result_unexpected: output event with no expected sweep");
            end else begin
               s = exp_q.pop_front();
               chk("valid", bus.valid, s.valid);
               for (int c = 0; c < CH; c++) begin
                  bus.rd_sel = SW'(c);
                  #1;
                  chk($sformatf("rd_data[%0d]", c), bus.rd_data, s.res[c]);
                  chk($sformatf("rd_timeout[%0d]", c), bus.rd_timeout, s.to[c]);
               end
            end
         end
      end
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; bus.start = 1'b0; bus.cont = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int c = 0; c < CH; c++) m_res[c] = '0;
      m_to = '0; m_valid = '0;
      exp_q.delete(); exp_trig_q.delete();
      last_trig_end = -1;
   endtask

   task automatic request_check();
      push_snapshot();
      @(posedge clk); #1 chk_req = 1'b1;
      @(posedge clk); #1 chk_req = 1'b0;
   endtask

   task automatic start_sweep(input logic [CH-1:0] mask);
      @(negedge clk);
      bus.ch_mask = mask; bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget, output int n);
      bit dropped;
      n = 0; dropped = 1'b0;
      while (bus.done !== 1'b1 && n < budget) begin
         if (bus.busy !== 1'b1) dropped = 1'b1;
         @(negedge clk); n++;
      end
      chk({name, "_done_seen"}, n < budget, 1);
      chk({name, "_busy_held"}, dropped, 0);
   endtask

   task automatic wait_quiet();
      int n = 0;
      while (sens_en != '0 && n < 300) begin @(negedge clk); n++; end
      chk("sensors_quiet", n < 300, 1);
   endtask

   task automatic set_sensor(input int c, input int d, input int len);
      sens_delay[c] = d; sens_len[c] = len;
   endtask

   initial begin
      int n, d0;
      logic [CH-1:0] mask;
      bus.start = 1'b0; bus.cont = 1'b0; bus.ch_mask = '0;
      for (int c = 0; c < CH; c++) set_sensor(c, 8, 20);
      do_reset();

      // reset state
      @(negedge clk);
      chk("reset_busy", bus.busy, 0);
      chk("reset_done", bus.done, 0);
      chk("reset_sig", sig_w, 0);
      request_check();

      // single channel, echo of 37
      set_sensor(0, 8, 37);
      plan_sweep(4'b0001); start_sweep(4'b0001); wait_done("single", 1000, n);
      @(negedge clk); chk("single_busy_low", bus.busy, 0);

      // ordering ch1 then ch3
      set_sensor(1, 5, 12); set_sensor(3, 9, 50);
      plan_sweep(4'b1010); start_sweep(4'b1010); wait_done("order", 1000, n);
      @(negedge clk); chk("order_busy_low", bus.busy, 0);
      wait_quiet();

      // rise timeout on ch0, stuck-high echo on ch2
      set_sensor(0, 4, 0); set_sensor(2, 4, -1);
      plan_sweep(4'b0101); start_sweep(4'b0101); wait_done("timeout", 1000, n);
      @(negedge clk); chk("timeout_busy_low", bus.busy, 0);
      sens_en[2] = 1'b0; sens_hl[2] = 0; set_sensor(2, 4, 20);
      wait_quiet();

      // continuous mode: 20 then 30, cont dropped during the second sweep
      d0 = done_cnt;
      set_sensor(0, 6, 20); plan_sweep(4'b0001);
      set_sensor(0, 6, 30); plan_sweep(4'b0001);
      set_sensor(0, 6, 20);
      bus.cont = 1'b1;
      start_sweep(4'b0001); wait_done("cont1", 1000, n);
      sens_len[0] = 30;
      @(negedge clk); chk("cont_busy_after_done", bus.busy, 1);
      repeat (2) @(negedge clk);
      bus.cont = 1'b0;
      wait_done("cont2", 1000, n);
      @(negedge clk); chk("cont_busy_low", bus.busy, 0);
      repeat (40) @(negedge clk);
      chk("cont_done_count", done_cnt - d0, 2);
      wait_quiet();

      // start while busy is ignored
      d0 = done_cnt;
      set_sensor(0, 3, 15); set_sensor(1, 3, 25);
      plan_sweep(4'b0011); start_sweep(4'b0011);
      repeat (15) @(negedge clk);
      bus.ch_mask = 4'b1111; bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
      wait_done("busy_start", 1000, n);
      repeat (60) @(negedge clk);
      chk("busy_start_done_count", done_cnt - d0, 1);
      chk("busy_start_idle", bus.busy, 0);

      // empty mask: busy for two cycles, one done, nothing driven or written
      plan_sweep(4'b0000); start_sweep(4'b0000); wait_done("empty", 100, n);
      chk("empty_latency", n, 1);
      @(negedge clk); chk("empty_busy_low", bus.busy, 0);

      // randomized sweeps
      for (int k = 0; k < 6; k++) begin
         wait_quiet();
         mask = CH'($urandom_range(0, 15));
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 9) == 0) set_sensor(c, $urandom_range(1, 12), 0);
            else set_sensor(c, $urandom_range(1, 12), $urandom_range(1, 130));
         end
         plan_sweep(mask); start_sweep(mask); wait_done("rand", 2000, n);
         @(negedge clk); chk("rand_busy_low", bus.busy, 0);
      end
      wait_quiet();

      // reset while measuring
      set_sensor(0, 3, 60);
      exp_trig_q.push_back(0);
      start_sweep(4'b0001);
      n = 0;
      while (sens_en[0] !== 1'b1 && n < 100) begin @(negedge clk); n++; end
      chk("measure_reached", n < 100, 1);
      repeat (10) @(negedge clk);
      do_reset();
      @(negedge clk);
      chk("midreset_sig", sig_w, 0);
      chk("midreset_busy", bus.busy, 0);
      request_check();
      set_sensor(0, 5, 25);
      plan_sweep(4'b0001); start_sweep(4'b0001); wait_done("after_reset", 1000, n);
      @(negedge clk); chk("after_reset_busy_low", bus.busy, 0);
      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);
      chk("triggers_drained", exp_trig_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
